vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/sync_edge_detect.sv | 35 +++
 rtl/vga_sync_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default widths, decoder FSM encoding and
// generator timing constants (640x480 @ 60 Hz, 25.175 MHz pixel clock).
package vga_pkg;

    // Default widths for the sync decoder counters and registers
    localparam int DEF_CNT_W      = 11;
    localparam int DEF_LIN_W      = 10;
    localparam int DEF_LOCK_LINES = 4;

    // Width of the consecutive-match counter; covers lock depths up to 15
    localparam int MATCH_W = 4;

    // Horizontal lock tracking states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

    // Generator timing, horizontal (pixels)
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Generator timing, vertical (lines)
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Saturating increment of the match counter
    function automatic logic [MATCH_W-1:0] match_sat_inc(input logic [MATCH_W-1:0] cnt);
        logic [MATCH_W-1:0] res;
        if (cnt == {MATCH_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(MATCH_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous sync pin into the clk domain with a two-flop
// synchronizer, keeps the previous synchronized level and flags the
// leading (inactive -> active) edge for the selected polarity.
module sync_edge_detect #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic lead_edge
);

    // All stages rest at the inactive level so reset release never looks like an edge
    localparam bit INACTIVE = ~POL;

    logic meta_r;
    logic stage_r;
    logic prev_r;

    // Synchronizer chain plus previous-level register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r  <= INACTIVE;
            stage_r <= INACTIVE;
            prev_r  <= INACTIVE;
        end else begin
            meta_r  <= sync_in;
            stage_r <= meta_r;
            prev_r  <= stage_r;
        end
    end

    assign lead_edge = (stage_r == POL) && (prev_r != POL);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from incoming VGA sync pins, measures line
// period and frame length, and tracks whether horizontal timing is stable.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LIN_W      = DEF_LIN_W,
    parameter int LOCK_LINES = DEF_LOCK_LINES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [CNT_W-1:0] x_pos,
    output logic [LIN_W-1:0] y_pos,
    output logic [CNT_W-1:0] line_len,
    output logic [LIN_W-1:0] frame_lines,
    output logic             locked,
    output logic             new_frame,
    output logic             sync_err
);

    localparam logic [CNT_W-1:0]   X_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   X_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   X_MAX    = {CNT_W{1'b1}};
    localparam logic [LIN_W-1:0]   Y_ZERO   = {LIN_W{1'b0}};
    localparam logic [LIN_W-1:0]   Y_ONE    = {{(LIN_W-1){1'b0}}, 1'b1};
    localparam logic [LIN_W-1:0]   Y_MAX    = {LIN_W{1'b1}};
    localparam logic [MATCH_W-1:0] M_ZERO   = {MATCH_W{1'b0}};
    localparam logic [MATCH_W-1:0] M_ONE    = {{(MATCH_W-1){1'b0}}, 1'b1};
    localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_LINES);

    logic               h_edge_s;
    logic               v_edge_s;

    sync_state_e        state_r;
    sync_state_e        state_nxt_s;
    logic [CNT_W-1:0]   x_pos_r;
    logic [CNT_W-1:0]   line_len_r;
    logic [CNT_W-1:0]   line_len_nxt_s;
    logic [CNT_W-1:0]   period_s;
    logic               x_sat_s;
    logic [MATCH_W-1:0] match_r;
    logic [MATCH_W-1:0] match_nxt_s;
    logic [MATCH_W-1:0] match_inc_s;
    logic               sync_err_nxt_s;
    logic               sync_err_r;
    logic               locked_r;

    logic [LIN_W-1:0]   y_pos_r;
    logic [LIN_W-1:0]   y_inc_s;
    logic [LIN_W-1:0]   frame_lines_r;
    logic               frame_pend_r;
    logic               frame_seen_r;
    logic               new_frame_r;

    sync_edge_detect #(
        .POL       (HSYNC_POL)
    ) u_hsync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_in   (hsync_in),
        .lead_edge (h_edge_s)
    );

    sync_edge_detect #(
        .POL       (VSYNC_POL)
    ) u_vsync_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_in   (vsync_in),
        .lead_edge (v_edge_s)
    );

    // Derived arithmetic: measured period, saturation flag, counter increments
    always_comb begin
        period_s    = x_pos_r + X_ONE;
        x_sat_s     = (x_pos_r == X_MAX);
        match_inc_s = match_sat_inc(match_r);
        if (y_pos_r == Y_MAX) begin
            y_inc_s = Y_MAX;
        end else begin
            y_inc_s = y_pos_r + Y_ONE;
        end
    end

    // Lock FSM next-state, training registers and loss-of-lock pulse
    always_comb begin
        state_nxt_s    = state_r;
        line_len_nxt_s = line_len_r;
        match_nxt_s    = match_r;
        sync_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (h_edge_s) begin
                    state_nxt_s = ST_TRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (x_sat_s) begin
                    // No edge for a full counter range: timing is gone
                    state_nxt_s    = ST_IDLE;
                    line_len_nxt_s = X_ZERO;
                    match_nxt_s    = M_ZERO;
                end else if (h_edge_s) begin
                    if (period_s == line_len_r) begin
                        match_nxt_s = match_inc_s;
                        if (match_inc_s == LOCK_CNT) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_TRAIN;
                        end
                    end else begin
                        line_len_nxt_s = period_s;
                        match_nxt_s    = M_ONE;
                        state_nxt_s    = ST_TRAIN;
                    end
                end else begin
                    state_nxt_s = ST_TRAIN;
                end
            end
            ST_LOCKED: begin
                if (x_sat_s) begin
                    state_nxt_s    = ST_IDLE;
                    line_len_nxt_s = X_ZERO;
                    match_nxt_s    = M_ZERO;
                    sync_err_nxt_s = 1'b1;
                end else if (h_edge_s && (period_s != line_len_r)) begin
                    state_nxt_s    = ST_TRAIN;
                    line_len_nxt_s = period_s;
                    match_nxt_s    = M_ONE;
                    sync_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                line_len_nxt_s = X_ZERO;
                match_nxt_s    = M_ZERO;
            end
        endcase
    end

    // Lock FSM state, training registers and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            line_len_r <= X_ZERO;
            match_r    <= M_ZERO;
            locked_r   <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            line_len_r <= line_len_nxt_s;
            match_r    <= match_nxt_s;
            locked_r   <= (state_nxt_s == ST_LOCKED);
            sync_err_r <= sync_err_nxt_s;
        end
    end

    // Horizontal position: restart on hsync leading edge, otherwise count and saturate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_pos_r <= X_ZERO;
        end else if (h_edge_s) begin
            x_pos_r <= X_ZERO;
        end else if (!x_sat_s) begin
            x_pos_r <= x_pos_r + X_ONE;
        end else begin
            x_pos_r <= x_pos_r;
        end
    end

    // Line counting and frame start; a vsync edge is applied on the next hsync edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_pos_r       <= Y_ZERO;
            frame_lines_r <= Y_ZERO;
            frame_pend_r  <= 1'b0;
            frame_seen_r  <= 1'b0;
            new_frame_r   <= 1'b0;
        end else begin
            new_frame_r <= 1'b0;
            if (h_edge_s && (frame_pend_r || v_edge_s)) begin
                y_pos_r      <= Y_ZERO;
                frame_pend_r <= 1'b0;
                new_frame_r  <= 1'b1;
                // The first frame after reset has no complete predecessor to measure
                if (frame_seen_r) begin
                    frame_lines_r <= y_inc_s;
                end else begin
                    frame_seen_r <= 1'b1;
                end
            end else if (h_edge_s) begin
                y_pos_r <= y_inc_s;
            end else if (v_edge_s) begin
                frame_pend_r <= 1'b1;
            end else begin
                frame_pend_r <= frame_pend_r;
            end
        end
    end

    assign x_pos       = x_pos_r;
    assign y_pos       = y_pos_r;
    assign line_len    = line_len_r;
    assign frame_lines = frame_lines_r;
    assign locked      = locked_r;
    assign new_frame   = new_frame_r;
    assign sync_err    = sync_err_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: default-polarity instance plus an active-high
// hsync instance fed the inverted pin; per-line expectations flow through a
// scoreboard queue and are checked three clocks after each leading edge.
module tb_vga_sync_decoder;

    localparam int HS_W = 8;
    localparam int VS_W = 12;

    logic        clk;
    logic        reset_n;
    logic        hsync;
    logic        vsync;
    logic        hsync_inv;

    logic [10:0] x_pos,  x_pos2;
    logic [9:0]  y_pos,  y_pos2;
    logic [10:0] line_len, line_len2;
    logic [9:0]  frame_lines, frame_lines2;
    logic        locked, locked2;
    logic        new_frame, new_frame2;
    logic        sync_err, sync_err2;

    int n_checks;
    int n_errors;
    int nf_run, nf_pulses, nf_bad;
    int err_run, err_pulses, err_bad;

    typedef struct {
        int period;
        bit exp_lock;
        int exp_len;
        int exp_y;
        int exp_fl;
        bit exp_nf;
    } line_exp_t;

    line_exp_t sb_q[$];

    assign hsync_inv = ~hsync;

    vga_sync_decoder u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hsync_in    (hsync),
        .vsync_in    (vsync),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .locked      (locked),
        .new_frame   (new_frame),
        .sync_err    (sync_err)
    );

    vga_sync_decoder #(
        .HSYNC_POL   (1'b1)
    ) u_dut_hpos (
        .clk         (clk),
        .reset_n     (reset_n),
        .hsync_in    (hsync_inv),
        .vsync_in    (vsync),
        .x_pos       (x_pos2),
        .y_pos       (y_pos2),
        .line_len    (line_len2),
        .frame_lines (frame_lines2),
        .locked      (locked2),
        .new_frame   (new_frame2),
        .sync_err    (sync_err2)
    );

    // Pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and width tracking for the one-cycle outputs
    initial begin
        nf_run = 0; nf_pulses = 0; nf_bad = 0;
        err_run = 0; err_pulses = 0; err_bad = 0;
    end
    always @(negedge clk) begin
        if (new_frame) begin
            nf_run++;
        end else begin
            if (nf_run != 0) begin
                nf_pulses++;
                if (nf_run != 1) nf_bad++;
            end
            nf_run = 0;
        end
        if (sync_err) begin
            err_run++;
        end else begin
            if (err_run != 0) begin
                err_pulses++;
                if (err_run != 1) err_bad++;
            end
            err_run = 0;
        end
    end

    // Time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // One hsync line; vs_at < 0 means no vsync pulse in this line
    task automatic run_line(input int period, input int vs_at, input bit exp_lock,
                            input int exp_len, input int exp_y, input int exp_fl,
                            input bit exp_nf);
        line_exp_t e;
        line_exp_t o;
        e.period   = period;
        e.exp_lock = exp_lock;
        e.exp_len  = exp_len;
        e.exp_y    = exp_y;
        e.exp_fl   = exp_fl;
        e.exp_nf   = exp_nf;
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            if (i == 0) sb_q.push_back(e);
            if (i == 3) begin
                chk("sb_depth", sb_q.size(), 1);
                if (sb_q.size() != 0) begin
                    o = sb_q.pop_front();
                    chk("x_pos_lead", x_pos, 0);
                    chk("locked", locked, o.exp_lock);
                    chk("line_len", line_len, o.exp_len);
                    chk("locked_hpos", locked2, o.exp_lock);
                    chk("line_len_hpos", line_len2, o.exp_len);
                    chk("new_frame", new_frame, o.exp_nf);
                    if (o.exp_y >= 0) chk("y_pos", y_pos, o.exp_y);
                    if (o.exp_fl >= 0) chk("frame_lines", frame_lines, o.exp_fl);
                end
            end
            if (i == period - 1 && period < 2000) chk("x_pos_end", x_pos, period - 4);
            hsync = (i < HS_W) ? 1'b0 : 1'b1;
            if (vs_at >= 0 && i == vs_at) vsync = 1'b0;
            else if (vs_at >= 0 && i == vs_at + VS_W) vsync = 1'b1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, x_pos, 0);
        chk({tag, "_y"}, y_pos, 0);
        chk({tag, "_len"}, line_len, 0);
        chk({tag, "_fl"}, frame_lines, 0);
        chk({tag, "_lock"}, locked, 0);
        chk({tag, "_nf"}, new_frame, 0);
        chk({tag, "_err"}, sync_err, 0);
        chk({tag, "_lock_hpos"}, locked2, 0);
        chk({tag, "_len_hpos"}, line_len2, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        hsync    = 1'b1;
        vsync    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b1;

        // Lock on 321-clock lines: locked after the 5th leading edge
        run_line(321, -1, 1'b0, 0,   -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b1, 321, -1, 0, 1'b0);
        chk("err_after_lock", err_pulses, 0);

        // One short line while locked, then relock on four 321 lines
        run_line(300, -1, 1'b1, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 300, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b1, 321, -1, 0, 1'b0);
        chk("err_short_line", err_pulses, 1);

        // hsync held inactive past the counter range while locked
        run_line(2200, -1, 1'b1, 321, -1, 0, 1'b0);
        chk("sat_x_pos", x_pos, 2047);
        chk("sat_locked", locked, 0);
        chk("sat_line_len", line_len, 0);
        chk("sat_line_len_hpos", line_len2, 0);
        chk("sat_err", err_pulses, 2);

        // Frames of 240 short lines: vsync coincident, mid-line, coincident
        for (int k = 0; k < 485; k++) begin
            int vs;
            vs = -1;
            if (k == 0 || k == 480) vs = 0;
            if (k == 239) vs = 20;
            run_line(40, vs, (k >= 4), (k == 0) ? 0 : 40, k % 240,
                     (k >= 240) ? 240 : 0, (k == 0 || k == 240 || k == 480));
        end
        chk("frame_err", err_pulses, 2);

        // Asynchronous reset mid-frame while locked, then relock
        repeat (100) @(negedge clk);
        chk("pre_reset_locked", locked, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        repeat (5) @(negedge clk);
        chk_all_zero("held_rst");
        reset_n = 1'b1;
        run_line(321, -1, 1'b0, 0,   -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b0, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b1, 321, -1, 0, 1'b0);
        run_line(321, -1, 1'b1, 321, -1, 0, 1'b0);

        chk("err_total", err_pulses, 2);
        chk("err_width", err_bad, 0);
        chk("nf_total", nf_pulses, 3);
        chk("nf_width", nf_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
